// File: rtl/psg_core.sv
// Programmable sound generator: square-wave tone channels with attack/hold/release envelopes,
// an LFSR noise source, a saturating mixer and a PWM output stage.
module psg_core #(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned PERIOD_W = 12,
   parameter int unsigned PWM_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_strobe,
   input  logic [3:0]        address,
   input  logic [7:0]        data,
   output logic              signal_out,
   output logic [NUM_CH-1:0] wave_o,
   output logic              noise_o,
   output logic [PWM_W-1:0]  mix_o
);

   typedef enum logic [1:0] {StIdle, StAttack, StHold, StRelease} env_st_e;

   localparam logic [PERIOD_W-1:0] PerOne = PERIOD_W'(1);
   localparam int unsigned         MixMax = (1 << PWM_W) - 1;

   // Register file
   logic [PERIOD_W-1:0] period_q [NUM_CH];
   logic [7:0]          shadow_q [NUM_CH];
   logic [3:0]          vol_q    [NUM_CH];
   logic [NUM_CH-1:0]   tone_en_q;
   logic                noise_en_q;
   logic [3:0]          noise_vol_q, noise_div_q;
   logic [7:0]          rate_q;

   // Channel state
   logic [PERIOD_W-1:0] cnt_q [NUM_CH], cnt_d [NUM_CH];
   logic [NUM_CH-1:0]   wave_q, wave_d;
   logic [3:0]          lvl_q [NUM_CH], lvl_d [NUM_CH];
   env_st_e             st_q  [NUM_CH], st_d  [NUM_CH];
   logic [NUM_CH-1:0]   en_prev_q, active;
   logic [7:0]          pre_q, pre_d;
   logic                tick;

   // Noise, mixer and PWM state
   logic [14:0]         lfsr_q, lfsr_d;
   logic [3:0]          ndiv_q, ndiv_d;
   logic                shift;
   logic [10:0]         sum;
   logic [7:0]          prod;
   logic [PWM_W-1:0]    mix_q, mix_d, duty_q, duty_d, pwm_q;
   logic                sig_q, sig_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            period_q[c] <= '0;
            shadow_q[c] <= '0;
            vol_q[c]    <= '0;
         end
         tone_en_q   <= '0;
         noise_en_q  <= 1'b0;
         noise_vol_q <= '0;
         noise_div_q <= '0;
         rate_q      <= '0;
      end else if (write_strobe) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (address == 4'(2 * c)) shadow_q[c] <= data;
            // High byte commits the whole period at once so the counter never sees a torn value
            if (address == 4'(2 * c + 1)) begin
               period_q[c] <= {data[PERIOD_W-9:0], shadow_q[c]};
               vol_q[c]    <= data[7:4];
            end
         end
         case (address)
            4'd8: begin
               noise_vol_q <= data[3:0];
               noise_div_q <= data[7:4];
            end
            4'd9: begin
               tone_en_q  <= data[NUM_CH-1:0];
               noise_en_q <= data[7];
            end
            4'd10:   rate_q <= data;
            default: ;
         endcase
      end
   end

   always_comb begin
      tick   = (pre_q >= rate_q);
      pre_d  = tick ? '0 : pre_q + 8'd1;
      active = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         active[c] = tone_en_q[c] | (lvl_q[c] != 4'd0);
         cnt_d[c]  = cnt_q[c];
         wave_d[c] = wave_q[c];
         if (!active[c] || (period_q[c] == '0)) begin
            cnt_d[c]  = '0;
            wave_d[c] = 1'b0;
         end else if (cnt_q[c] >= period_q[c] - PerOne) begin
            cnt_d[c]  = '0;
            wave_d[c] = ~wave_q[c];
         end else begin
            cnt_d[c] = cnt_q[c] + PerOne;
         end

         st_d[c]  = st_q[c];
         lvl_d[c] = lvl_q[c];
         if (tone_en_q[c] && !en_prev_q[c]) begin
            st_d[c] = StAttack;
         end else if (!tone_en_q[c] && en_prev_q[c] &&
                      ((st_q[c] == StAttack) || (st_q[c] == StHold))) begin
            st_d[c] = StRelease;
         end
         // The level step is applied in the same edge as the transition into a ramp state
         case (st_d[c])
            StAttack: begin
               if (lvl_q[c] == 4'd15) begin
                  st_d[c] = StHold;
               end else if (tick) begin
                  lvl_d[c] = lvl_q[c] + 4'd1;
                  if (lvl_q[c] == 4'd14) st_d[c] = StHold;
               end
            end
            StRelease: begin
               if (lvl_q[c] == 4'd0) begin
                  st_d[c] = StIdle;
               end else if (tick) begin
                  lvl_d[c] = lvl_q[c] - 4'd1;
                  if (lvl_q[c] == 4'd1) st_d[c] = StIdle;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= '0;
            lvl_q[c] <= '0;
            st_q[c]  <= StIdle;
         end
         wave_q    <= '0;
         en_prev_q <= '0;
         pre_q     <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= cnt_d[c];
            lvl_q[c] <= lvl_d[c];
            st_q[c]  <= st_d[c];
         end
         wave_q    <= wave_d;
         en_prev_q <= tone_en_q;
         pre_q     <= pre_d;
      end
   end

   always_comb begin
      shift  = noise_en_q && (ndiv_q >= noise_div_q);
      ndiv_d = (!noise_en_q || shift) ? '0 : ndiv_q + 4'd1;
      lfsr_d = shift ? {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]} : lfsr_q;

      sum  = '0;
      prod = '0;
      if (noise_en_q && lfsr_q[0]) sum = {7'd0, noise_vol_q};
      for (int c = 0; c < NUM_CH; c++) begin
         prod = {4'd0, vol_q[c]} * {4'd0, lvl_q[c]};
         if (wave_q[c]) sum = sum + {7'd0, prod[7:4]};
      end
      mix_d = (sum > 11'(MixMax)) ? '1 : sum[PWM_W-1:0];

      // Duty only follows the mix at the period boundary to avoid mid-period glitches
      duty_d = (&pwm_q) ? mix_q : duty_q;
      sig_d  = (pwm_q < duty_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= 15'h0001;
         ndiv_q <= '0;
         mix_q  <= '0;
         duty_q <= '0;
         pwm_q  <= '0;
         sig_q  <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         ndiv_q <= ndiv_d;
         mix_q  <= mix_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_q + PWM_W'(1);
         sig_q  <= sig_d;
      end
   end

   assign wave_o     = wave_q;
   assign mix_o      = mix_q;
   assign signal_out = sig_q;
   // LFSR resets to 1, so the bit is gated to keep the output low while reset is held
   assign noise_o    = lfsr_q[0] & rst;

endmodule

// File: tb/tb_psg_core.sv
// Directed testbench for psg_core: a default 3-channel instance and a 4-channel, 6-bit PWM
// instance share the write bus, so channel-3 writes also show the 3-channel decode ignoring them.
module tb_psg_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       write_strobe = 1'b0;
   logic [3:0] address = '0;
   logic [7:0] data = '0;

   logic       sig3, noise3, sig4, noise4;
   logic [2:0] wave3;
   logic [3:0] wave4;
   logic [7:0] mix3;
   logic [5:0] mix4;

   int errors = 0;
   int checks = 0;

   psg_core #(.NUM_CH(3), .PERIOD_W(12), .PWM_W(8)) dut3 (
      .clk(clk), .rst(rst), .write_strobe(write_strobe), .address(address), .data(data),
      .signal_out(sig3), .wave_o(wave3), .noise_o(noise3), .mix_o(mix3)
   );

   psg_core #(.NUM_CH(4), .PERIOD_W(12), .PWM_W(6)) dut4 (
      .clk(clk), .rst(rst), .write_strobe(write_strobe), .address(address), .data(data),
      .signal_out(sig4), .wave_o(wave4), .noise_o(noise4), .mix_o(mix4)
   );

   always #5 clk = ~clk;

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address = a;
      data = d;
      write_strobe = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      wait_n(2);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      checks++; if (wave3 !== 3'b0)  begin errors++; $display("FAIL rst_wave3: got %b want 0", wave3); end
      checks++; if (mix3 !== 8'd0)   begin errors++; $display("FAIL rst_mix3: got %0d want 0", mix3); end
      checks++; if (sig3 !== 1'b0)   begin errors++; $display("FAIL rst_sig3: got %b want 0", sig3); end
      checks++; if (noise3 !== 1'b0) begin errors++; $display("FAIL rst_noise3: got %b want 0", noise3); end
      checks++; if (wave4 !== 4'b0)  begin errors++; $display("FAIL rst_wave4: got %b want 0", wave4); end
      checks++; if (mix4 !== 6'd0)   begin errors++; $display("FAIL rst_mix4: got %0d want 0", mix4); end
      wait_n(2);
      rst = 1'b1;
      wait_n(3);
      checks++; if (noise3 !== 1'b1) begin errors++; $display("FAIL rst_lfsr_seed: got %b want 1", noise3); end
      checks++; if (mix3 !== 8'd0)   begin errors++; $display("FAIL idle_mix3: got %0d want 0", mix3); end
   endtask

   task automatic test_tone_env();
      do_reset();
      wr(4'd0, 8'h05);
      wr(4'd1, 8'hF0);
      wr(4'd9, 8'h01);
      wait_n(4);
      checks++; if (wave3[0] !== 1'b0) begin errors++; $display("FAIL tone_w4: got %b want 0", wave3[0]); end
      wait_n(1);
      checks++; if (wave3[0] !== 1'b1) begin errors++; $display("FAIL tone_w5: got %b want 1", wave3[0]); end
      wait_n(1);
      checks++; if (mix3 !== 8'd4)     begin errors++; $display("FAIL tone_mix6: got %0d want 4", mix3); end
      wait_n(3);
      checks++; if (wave3[0] !== 1'b1) begin errors++; $display("FAIL tone_w9: got %b want 1", wave3[0]); end
      wait_n(1);
      checks++; if (wave3[0] !== 1'b0) begin errors++; $display("FAIL tone_w10: got %b want 0", wave3[0]); end
      checks++; if (mix3 !== 8'd8)     begin errors++; $display("FAIL tone_mix10: got %0d want 8", mix3); end
      wait_n(1);
      checks++; if (mix3 !== 8'd0)     begin errors++; $display("FAIL tone_mix11: got %0d want 0", mix3); end
      wait_n(4);
      checks++; if (wave3[0] !== 1'b1) begin errors++; $display("FAIL tone_w15: got %b want 1", wave3[0]); end
      wait_n(1);
      checks++; if (mix3 !== 8'd14)    begin errors++; $display("FAIL env_full3: got %0d want 14", mix3); end
      checks++; if (mix4 !== 6'd14)    begin errors++; $display("FAIL env_full4: got %0d want 14", mix4); end
   endtask

   task automatic test_shadow_release();
      do_reset();
      wr(4'd0, 8'h05);
      wr(4'd1, 8'hF0);
      wr(4'd9, 8'h01);
      wr(4'd0, 8'h20);
      wait_n(4);
      checks++; if (wave3[0] !== 1'b1) begin errors++; $display("FAIL shadow_w5: got %b want 1", wave3[0]); end
      wait_n(5);
      checks++; if (wave3[0] !== 1'b0) begin errors++; $display("FAIL shadow_w10: got %b want 0", wave3[0]); end
      wr(4'd1, 8'hF0);
      wait_n(4);
      checks++; if (wave3[0] !== 1'b0) begin errors++; $display("FAIL commit_w15: got %b want 0", wave3[0]); end
      wait_n(26);
      checks++; if (wave3[0] !== 1'b0) begin errors++; $display("FAIL commit_w41: got %b want 0", wave3[0]); end
      wait_n(1);
      checks++; if (wave3[0] !== 1'b1) begin errors++; $display("FAIL commit_w42: got %b want 1", wave3[0]); end
      wait_n(2);
      checks++; if (mix3 !== 8'd14)    begin errors++; $display("FAIL commit_mix: got %0d want 14", mix3); end
      wr(4'd9, 8'h00);
      wait_n(2);
      checks++; if (mix3 !== 8'd13)    begin errors++; $display("FAIL rel_mix2: got %0d want 13", mix3); end
      wait_n(4);
      checks++; if (mix3 !== 8'd9)     begin errors++; $display("FAIL rel_mix6: got %0d want 9", mix3); end
      wait_n(9);
      checks++; if (wave3[0] !== 1'b1) begin errors++; $display("FAIL rel_w15: got %b want 1", wave3[0]); end
      wait_n(1);
      checks++; if (wave3[0] !== 1'b0) begin errors++; $display("FAIL rel_w16: got %b want 0", wave3[0]); end
      checks++; if (mix3 !== 8'd0)     begin errors++; $display("FAIL rel_mix16: got %0d want 0", mix3); end
      wait_n(50);
      checks++; if (wave3[0] !== 1'b0) begin errors++; $display("FAIL rel_hold: got %b want 0", wave3[0]); end
   endtask

   task automatic test_mix_sat_pwm();
      int hi3, hi4;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         wr(4'(2 * c), 8'hC0);
         wr(4'(2 * c + 1), 8'hF0);
      end
      wr(4'd8, 8'hFF);
      wr(4'd9, 8'h0F);
      hi3 = 0;
      hi4 = 0;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         hi3 += int'(sig3);
         hi4 += int'(sig4);
      end
      checks++; if (hi3 != 0) begin errors++; $display("FAIL duty0_3: got %0d highs want 0", hi3); end
      checks++; if (hi4 != 0) begin errors++; $display("FAIL duty0_4: got %0d highs want 0", hi4); end
      wait_n(72);
      checks++; if (mix3 !== 8'd42) begin errors++; $display("FAIL mix_ch3: got %0d want 42", mix3); end
      checks++; if (mix4 !== 6'd56) begin errors++; $display("FAIL mix_ch4: got %0d want 56", mix4); end
      wait_n(59);
      hi4 = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         hi4 += int'(sig4);
      end
      checks++; if (hi4 != 56) begin errors++; $display("FAIL pwm_duty56: got %0d highs want 56", hi4); end
      wr(4'd9, 8'h8F);
      wait_n(2);
      checks++; if (mix4 !== 6'd63) begin errors++; $display("FAIL mix_sat4: got %0d want 63", mix4); end
      checks++; if (mix3 !== 8'd57) begin errors++; $display("FAIL mix_noise3: got %0d want 57", mix3); end
      wait_n(13);
      checks++; if (noise3 !== 1'b1) begin errors++; $display("FAIL ndiv_n15: got %b want 1", noise3); end
      wait_n(1);
      checks++; if (noise4 !== 1'b0) begin errors++; $display("FAIL ndiv_n16: got %b want 0", noise4); end
      checks++; if (mix4 !== 6'd63)  begin errors++; $display("FAIL mix_sat4b: got %0d want 63", mix4); end
      wait_n(1);
      checks++; if (mix4 !== 6'd56)  begin errors++; $display("FAIL mix_unsat4: got %0d want 56", mix4); end
      checks++; if (mix3 !== 8'd42)  begin errors++; $display("FAIL mix_unsat3: got %0d want 42", mix3); end
   endtask

   task automatic test_lfsr();
      logic [14:0] m;
      int bad;
      do_reset();
      wr(4'd8, 8'h00);
      wr(4'd9, 8'h80);
      m = 15'h0001;
      bad = 0;
      for (int k = 0; k < 32800; k++) begin
         @(negedge clk);
         m = {m[13:0], m[14] ^ m[13]};
         if (noise3 !== m[0] || noise4 !== m[0]) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL lfsr_seq: got %0d bad bits want 0", bad); end
      wr(4'd9, 8'h00);
      m = {m[13:0], m[14] ^ m[13]};
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (noise3 !== m[0]) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL lfsr_freeze: got %0d bad bits want 0", bad); end
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      wr(4'd1, 8'hF0);
      wr(4'd10, 8'hFF);
      wr(4'd8, 8'h0F);
      wr(4'd9, 8'h81);
      n = 0;
      while (sig4 !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sig4 !== 1'b1) begin
         errors++;
         $display("FAIL arst_setup: got signal_out %b want 1 within 2000 cycles", sig4);
      end
      #2 rst = 1'b0;
      #1;
      checks++; if (sig4 !== 1'b0)   begin errors++; $display("FAIL arst_sig4: got %b want 0", sig4); end
      checks++; if (mix4 !== 6'd0)   begin errors++; $display("FAIL arst_mix4: got %0d want 0", mix4); end
      checks++; if (noise4 !== 1'b0) begin errors++; $display("FAIL arst_noise4: got %b want 0", noise4); end
      checks++; if (sig3 !== 1'b0)   begin errors++; $display("FAIL arst_sig3: got %b want 0", sig3); end
      checks++; if (mix3 !== 8'd0)   begin errors++; $display("FAIL arst_mix3: got %0d want 0", mix3); end
      @(negedge clk);
      rst = 1'b1;
      wait_n(2);
   endtask

   initial begin
      test_reset();
      test_tone_env();
      test_shadow_release();
      test_mix_sat_pwm();
      test_lfsr();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psg_core.md
PSG_CORE -- requirements
Module: psg_core

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, meaning number of tone channels, legal range 1..4.
REQ-002 The block SHALL have parameter PERIOD_W, default 12, meaning tone period width, legal range 9..12.
REQ-003 The block SHALL have parameter PWM_W, default 8, meaning PWM and mix resolution, legal range 6..10.
REQ-004 The block SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 write_strobe  in  1  register write enable, sampled on clk.
REQ-007 address  in  4  register address.
REQ-008 data  in  8  write data.
REQ-009 signal_out  out  1  PWM audio output.
REQ-010 wave_o  out  NUM_CH  per-channel square-wave state.
REQ-011 noise_o  out  1  LFSR noise bit.
REQ-012 mix_o  out  PWM_W  registered saturated mix level.

Function
REQ-013 Writes SHALL take effect at the clk edge where write_strobe=1; logic uses the new value from the next edge; unmapped addresses SHALL be ignored.
REQ-014 Register map, channel c: addr 2c = period low byte, held in a per-channel shadow register and not applied; addr 2c+1 = data[PERIOD_W-9:0] period high bits plus data[7:4] volume, committing {high, shadow} atomically to the period in the same edge.
REQ-015 Addr 8 = data[3:0] noise volume, data[7:4] noise divider; addr 9 = data[NUM_CH-1:0] tone enables, data[7] noise enable; addr 10 = data[7:0] envelope rate.
REQ-016 Addresses for c >= NUM_CH SHALL be ignored.
REQ-017 A channel is active when its enable=1 or its envelope level != 0.
REQ-018 When a channel is active and period P != 0, its counter SHALL increment each cycle; on the cycle where counter >= P-1, the counter SHALL clear and the wave SHALL toggle, giving full period 2P cycles.
REQ-019 A committed period below the current count SHALL cause a toggle on the next cycle.
REQ-020 If a channel is inactive or P=0, its counter and wave SHALL be held at 0.
REQ-021 The envelope prescaler SHALL count 0..rate and emit a one-cycle tick on reaching rate; rate 0 SHALL give a tick every cycle.
REQ-022 Each channel SHALL have a 4-bit envelope with states IDLE, ATTACK, HOLD, RELEASE.
REQ-023 Envelope transitions: enable 0->1 from any state goes to ATTACK (level continues from current value); ATTACK +1 per tick, entering HOLD at 15; enable 1->0 from ATTACK or HOLD goes to RELEASE; RELEASE -1 per tick, entering IDLE at 0; re-enable during RELEASE goes to ATTACK.
REQ-024 Noise SHALL use a 15-bit Fibonacci LFSR, taps x^15+x^14+1, shifting once every (divider+1) cycles while noise enable=1 and freezing otherwise; noise_o = lfsr[0].
REQ-025 Channel contribution SHALL be (vol*env)>>4 when its wave=1, else 0; noise contribution SHALL be noise volume when noise_o=1 and noise enable=1, else 0.
REQ-026 mix_o SHALL be the sum of all contributions, saturated at 2^PWM_W-1, registered with one cycle of latency after wave, env and noise.
REQ-027 The PWM counter SHALL be free-running 0..2^PWM_W-1 with wrap.
REQ-028 The duty register SHALL load mix_o only when the PWM counter is all-ones, so no mid-period duty change occurs.
REQ-029 signal_out SHALL be registered as (counter < duty); duty 0 SHALL give constant 0; duty at maximum SHALL give high for all but one cycle per PWM period.

Reset
REQ-030 While rst=0, the following SHALL hold asynchronously: periods, shadows, volumes, enables, rate and divider = 0; envelopes IDLE at level 0; counters, prescalers and PWM counter = 0; LFSR = 15'h0001; wave_o, noise_o, mix_o, duty and signal_out = 0.
REQ-031 Reset asserted mid-operation SHALL abort writes and envelopes without waiting for the next clock edge.
REQ-032 After rst deasserts, the first write SHALL be accepted at the first clk edge.

Verification
REQ-033 Scenario: NUM_CH=3; write addr0=0x05, addr1=0xF0, addr9=0x01, rate=0 -> wave_o[0] toggles every 5 cycles; envelope reaches 15 after 15 cycles.
REQ-034 Scenario: write addr0=0x20 only -> period unchanged and wave_o[0] unaffected until addr1 written; then period=0x020 applied atomically.
REQ-035 Scenario: channel 0 at env 15, vol 15; clear addr9 -> RELEASE; wave continues; level decrements 1 per tick to 0 in 15 ticks; wave_o[0] then held 0.
REQ-036 Scenario: NUM_CH=4, all vol 15, env 15, waves high, noise vol 15 -> 4*14+15=71 unsaturated; with PWM_W=6 -> mix_o saturates at 63.
REQ-037 Scenario: noise enabled with divider 0 -> LFSR sequence from 0x0001 matches the reference model and repeats after 32767 shifts.
REQ-038 Scenario: assert rst mid-attack with signal_out=1 -> all outputs 0 immediately, before the next clk edge.
